// File: rtl/mau_pkg.sv
// mau_pkg: shared encodings for the DataMemory access unit.
// MAU_WRITE_VERIFY_EN adds the VERIFY state to the FSM encoding.
package mau_pkg;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam int ERR_MISALIGN = 0;
    localparam int ERR_RANGE    = 1;
    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_SETUP,
        S_STROBE,
        S_HOLD,
`ifdef MAU_WRITE_VERIFY_EN
        S_VERIFY,
`endif
        S_RESP
    } state_t;
endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: request/response handshake between the CPU MEM stage and the access unit.
interface mem_access_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_err;
    logic        verify_err;
    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, verify_err
    );
    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err, verify_err
    );
endinterface

// File: rtl/mau_lane_merge.sv
// mau_lane_merge: little-endian lane insert (sub-word store) and extract/extend (load).
module mau_lane_merge
    import mau_pkg::*;
(
    input  logic [31:0] i_old,
    input  logic [31:0] i_data,
    input  logic [31:0] i_word,
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_off,
    input  logic        i_unsigned,
    output logic [31:0] o_merged,
    output logic [31:0] o_ext
);
    logic [4:0]  w_sh_b;
    logic [4:0]  w_sh_h;
    logic [4:0]  w_sh;
    logic [7:0]  w_b;
    logic [15:0] w_h;
    logic [31:0] w_mask;

    assign w_sh_b = {i_off, 3'b000};
    assign w_sh_h = {i_off[1], 4'b0000};
    assign w_b    = 8'(i_word >> w_sh_b);
    assign w_h    = 16'(i_word >> w_sh_h);
    assign o_ext  = (i_size == SZ_BYTE) ? {{24{!i_unsigned && w_b[7]}}, w_b} :
                    (i_size == SZ_HALF) ? {{16{!i_unsigned && w_h[15]}}, w_h} : i_word;
    assign w_sh   = (i_size == SZ_BYTE) ? w_sh_b : (i_size == SZ_HALF) ? w_sh_h : 5'd0;
    assign w_mask = (i_size == SZ_BYTE) ? (32'h0000_00FF << w_sh) :
                    (i_size == SZ_HALF) ? (32'h0000_FFFF << w_sh) : 32'hFFFF_FFFF;
    assign o_merged = (i_old & ~w_mask) | ((i_data << w_sh) & w_mask);
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: sequences DataMemory RW/DAddr/Datain for one load/store at a time,
// with read-modify-write for sub-word stores. MAU_WRITE_VERIFY_EN adds a read-back check.
module mem_access_unit
    import mau_pkg::*;
#(
    parameter int MEM_BYTES = 1024
) (
    input  logic               CLK,
    input  logic               Reset,
    mem_access_unit_if.slave   bus,
    output logic               RW,
    output logic [31:0]        DAddr,
    output logic [31:0]        Datain,
    input  logic [31:0]        DataOut
);
    state_t      r_state;
    state_t      w_next;
    logic        r_we;
    logic [1:0]  r_size;
    logic        r_uns;
    logic [1:0]  r_off;
    logic [31:0] r_wdata;
    logic [31:0] r_daddr;
    logic [31:0] r_datain;
    logic [31:0] r_rdata;
    logic [1:0]  r_err;
    logic        r_verr;
    logic [1:0]  w_err;
    logic        w_accept;
    logic [31:0] w_merged;
    logic [31:0] w_ext;

    assign w_accept            = (r_state == S_IDLE) && bus.req_valid;
    assign w_err[ERR_MISALIGN] = ((bus.req_size == SZ_HALF) && bus.req_addr[0]) ||
                                 (bus.req_size[1] && (bus.req_addr[1:0] != 2'b00));
    assign w_err[ERR_RANGE]    = bus.req_addr >= 32'(MEM_BYTES);

    mau_lane_merge u_lane (
        .i_old      (DataOut),
        .i_data     (r_wdata),
        .i_word     (DataOut),
        .i_size     (r_size),
        .i_off      (r_off),
        .i_unsigned (r_uns),
        .o_merged   (w_merged),
        .o_ext      (w_ext)
    );

    // State register; reset drops RW at once because RW decodes only STROBE.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state: errors skip memory, word stores skip the read, everything else reads first.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (bus.req_valid) w_next = (|w_err) ? S_RESP :
                                                  (bus.req_we && bus.req_size[1]) ? S_SETUP : S_RD;
            S_RD:     w_next = r_we ? S_SETUP : S_RESP;
            S_SETUP:  w_next = S_STROBE;
            S_STROBE: w_next = S_HOLD;
`ifdef MAU_WRITE_VERIFY_EN
            S_HOLD:   w_next = S_VERIFY;
            S_VERIFY: w_next = S_RESP;
`else
            S_HOLD:   w_next = S_RESP;
`endif
            default:  w_next = S_IDLE;
        endcase
    end

    // Request capture, memory pin registers and response registers loaded on entry to RESP.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_we     <= 1'b0;
            r_size   <= 2'b00;
            r_uns    <= 1'b0;
            r_off    <= 2'b00;
            r_wdata  <= '0;
            r_daddr  <= '0;
            r_datain <= '0;
            r_rdata  <= '0;
            r_err    <= '0;
            r_verr   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_we    <= bus.req_we;
                r_size  <= bus.req_size;
                r_uns   <= bus.req_unsigned;
                r_off   <= bus.req_addr[1:0];
                r_wdata <= bus.req_wdata;
                if (|w_err) begin
                    r_rdata <= '0;
                    r_err   <= w_err;
                    r_verr  <= 1'b0;
                end else begin
                    r_daddr <= {bus.req_addr[31:2], 2'b00};
                    if (bus.req_we && bus.req_size[1]) r_datain <= bus.req_wdata;
                end
            end
            if (r_state == S_RD) begin
                if (r_we) r_datain <= w_merged;
                else begin
                    r_rdata <= w_ext;
                    r_err   <= '0;
                    r_verr  <= 1'b0;
                end
            end
`ifdef MAU_WRITE_VERIFY_EN
            if (r_state == S_VERIFY) begin
                r_rdata <= '0;
                r_err   <= '0;
                r_verr  <= DataOut != r_datain;
            end
`else
            if (r_state == S_HOLD) begin
                r_rdata <= '0;
                r_err   <= '0;
                r_verr  <= 1'b0;
            end
`endif
        end
    end

    assign bus.req_ready  = r_state == S_IDLE;
    assign bus.resp_valid = r_state == S_RESP;
    assign bus.resp_rdata = r_rdata;
    assign bus.resp_err   = r_err;
    assign bus.verify_err = r_verr;
    assign RW             = r_state == S_STROBE;
    assign DAddr          = r_daddr;
    assign Datain         = r_datain;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: scoreboard bench for mem_access_unit against a word-wide DataMemory model.
// Honours MAU_WRITE_VERIFY_EN (extra store cycle, stuck-bit verify check).
module tb_mem_access_unit;
    import mau_pkg::*;
`ifdef MAU_WRITE_VERIFY_EN
    localparam int   VX         = 1;
    localparam logic STUCK_VERR = 1'b1;
`else
    localparam int   VX         = 0;
    localparam logic STUCK_VERR = 1'b0;
`endif

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  err;
        logic        verr;
        int          lat;
        int          c0;
    } exp_t;

    logic        CLK = 1'b0;
    logic        Reset = 1'b0;
    logic        RW;
    logic [31:0] DAddr;
    logic [31:0] Datain;
    logic [31:0] DataOut;
    logic [31:0] mem [0:255];
    logic        mem_clr = 1'b1;
    logic        stuck_en = 1'b0;
    int          cyc = 0;
    int          rw_cnt = 0;
    int          rw_cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    exp_t        sb[$];
    exp_t        e;

    mem_access_unit_if bus();

    mem_access_unit #(.MEM_BYTES(1024)) dut (
        .CLK     (CLK),
        .Reset   (Reset),
        .bus     (bus),
        .RW      (RW),
        .DAddr   (DAddr),
        .Datain  (Datain),
        .DataOut (DataOut)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(posedge CLK) begin
        if (mem_clr) for (int i = 0; i < 256; i++) mem[i] <= (i == 8) ? 32'h1234_5678 : 32'h0;
        else if (RW) mem[DAddr[9:2]] <= Datain & ~{31'b0, stuck_en};
    end

    assign DataOut = mem[DAddr[9:2]];

    always @(negedge CLK) begin
        if (RW) begin
            rw_cnt++;
            rw_cyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (bus.resp_valid) begin
            if (sb.size() == 0) check("resp_unexpected", 32'(bus.resp_valid), 32'd0);
            else begin
                e = sb.pop_front();
                check("resp_rdata", bus.resp_rdata, e.rdata);
                check("resp_err", 32'(bus.resp_err), 32'(e.err));
                check("verify_err", 32'(bus.verify_err), 32'(e.verr));
                check("latency", 32'(cyc - e.c0 + 1), 32'(e.lat));
            end
        end
    end

    task automatic send(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] exp_d,
                        input logic [1:0] exp_e, input logic exp_v, input int lat, output int c0);
        @(negedge CLK);
        check("req_ready", 32'(bus.req_ready), 32'd1);
        bus.req_we       = we;
        bus.req_size     = sz;
        bus.req_unsigned = uns;
        bus.req_addr     = a;
        bus.req_wdata    = wd;
        bus.req_valid    = 1'b1;
        @(posedge CLK);
        #1;
        bus.req_valid = 1'b0;
        c0 = cyc;
        sb.push_back('{exp_d, exp_e, exp_v, lat, c0});
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && sb.size() != 0; i++) @(posedge CLK);
        check("resp_timeout", 32'(sb.size()), 32'd0);
    endtask

    task automatic req(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] exp_d,
                       input logic [1:0] exp_e, input logic exp_v, input int lat);
        int c;
        send(we, sz, uns, a, wd, exp_d, exp_e, exp_v, lat, c);
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
        $fatal(1);
    end

    initial begin
        int c0;
        int r0;
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_size     = SZ_WORD;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = '0;
        bus.req_wdata    = '0;
        #1;
        check("rst_ready", 32'(bus.req_ready), 32'd1);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_rw", 32'(RW), 32'd0);
        check("rst_daddr", DAddr, 32'd0);
        check("rst_datain", Datain, 32'd0);
        check("rst_rdata", bus.resp_rdata, 32'd0);
        check("rst_err", 32'(bus.resp_err), 32'd0);
        check("rst_verr", 32'(bus.verify_err), 32'd0);
        repeat (3) @(negedge CLK);
        Reset   = 1'b1;
        mem_clr = 1'b0;

        r0 = rw_cnt;
        send(1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEAD_BEEF, 32'h0, 2'b00, 1'b0, 4 + VX, c0);
        check("sw_daddr_c1", DAddr, 32'h10);
        check("sw_datain_c1", Datain, 32'hDEAD_BEEF);
        check("sw_rw_c1", 32'(RW), 32'd0);
        drain();
        check("sw_rw_count", 32'(rw_cnt - r0), 32'd1);
        check("sw_rw_cycle", 32'(rw_cyc - c0 + 1), 32'd2);
        req(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 2'b00, 1'b0, 2);

        req(1'b1, SZ_BYTE, 1'b0, 32'h11, 32'h0000_00A5, 32'h0, 2'b00, 1'b0, 5 + VX);
        check("sb_mem", mem[4], 32'hDEAD_A5EF);
        req(1'b0, SZ_BYTE, 1'b0, 32'h11, 32'h0, 32'hFFFF_FFA5, 2'b00, 1'b0, 2);
        req(1'b0, SZ_BYTE, 1'b1, 32'h11, 32'h0, 32'h0000_00A5, 2'b00, 1'b0, 2);
        req(1'b1, SZ_HALF, 1'b0, 32'h12, 32'h1234_8001, 32'h0, 2'b00, 1'b0, 5 + VX);
        check("sh_mem", mem[4], 32'h8001_A5EF);
        req(1'b0, SZ_HALF, 1'b0, 32'h12, 32'h0, 32'hFFFF_8001, 2'b00, 1'b0, 2);
        req(1'b0, SZ_HALF, 1'b1, 32'h12, 32'h0, 32'h0000_8001, 2'b00, 1'b0, 2);
        req(1'b0, SZ_HALF, 1'b0, 32'h10, 32'h0, 32'hFFFF_A5EF, 2'b00, 1'b0, 2);
        req(1'b0, SZ_BYTE, 1'b0, 32'h10, 32'h0, 32'hFFFF_FFEF, 2'b00, 1'b0, 2);
        req(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'h8001_A5EF, 2'b00, 1'b0, 2);

        r0 = rw_cnt;
        req(1'b1, SZ_HALF, 1'b0, 32'h13, 32'hFFFF, 32'h0, 2'b01, 1'b0, 1);
        check("err_no_rw", 32'(rw_cnt - r0), 32'd0);
        check("err_mem_kept", mem[4], 32'h8001_A5EF);
        req(1'b0, SZ_WORD, 1'b0, 32'h400, 32'h0, 32'h0, 2'b10, 1'b0, 1);
        req(1'b0, SZ_WORD, 1'b0, 32'h3FC, 32'h0, 32'h0, 2'b00, 1'b0, 2);
        req(1'b0, SZ_WORD, 1'b0, 32'h401, 32'h0, 32'h0, 2'b11, 1'b0, 1);
        req(1'b1, SZ_WORD, 1'b0, 32'h3FE, 32'h1, 32'h0, 2'b01, 1'b0, 1);
        req(1'b0, SZ_HALF, 1'b0, 32'h402, 32'h0, 32'h0, 2'b10, 1'b0, 1);
        check("err_total_no_rw", 32'(rw_cnt - r0), 32'd0);

        @(negedge CLK);
        bus.req_we    = 1'b1;
        bus.req_size  = SZ_WORD;
        bus.req_addr  = 32'h20;
        bus.req_wdata = 32'hCAFE_F00D;
        bus.req_valid = 1'b1;
        @(posedge CLK);
        #1;
        bus.req_valid = 1'b0;
        @(posedge CLK);
        #1;
        check("rw_in_strobe", 32'(RW), 32'd1);
        #2;
        Reset = 1'b0;
        #1;
        check("rst_rw_drop", 32'(RW), 32'd0);
        check("rst_ready_mid", 32'(bus.req_ready), 32'd1);
        check("rst_no_resp", 32'(bus.resp_valid), 32'd0);
        repeat (2) @(negedge CLK);
        Reset = 1'b1;
        repeat (3) @(negedge CLK);
        check("rst_no_resp_after", 32'(bus.resp_valid), 32'd0);
        check("rst_mem_kept", mem[8], 32'h1234_5678);
        req(1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0, 32'h1234_5678, 2'b00, 1'b0, 2);

        stuck_en = 1'b1;
        req(1'b1, SZ_WORD, 1'b0, 32'h30, 32'h0000_0001, 32'h0, 2'b00, STUCK_VERR, 4 + VX);
        stuck_en = 1'b0;
        req(1'b1, SZ_WORD, 1'b0, 32'h34, 32'h0000_0001, 32'h0, 2'b00, 1'b0, 4 + VX);
        req(1'b0, SZ_WORD, 1'b0, 32'h34, 32'h0, 32'h0000_0001, 2'b00, 1'b0, 2);

        repeat (3) @(negedge CLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator-side controller for the DataMemory port (RW, DAddr, Datain, DataOut); sits between the CPU's execute/MEM stage and DataMemory.
- Accepts one load/store request at a time over a valid/ready handshake and sequences the memory pins with setup/strobe/hold timing.
- Performs read-modify-write for byte and halfword stores, and sign/zero extension for byte and halfword loads.
- Returns one response per request: data plus error flags.

Parameters:
- MEM_BYTES, 1024, size of the DataMemory address space in bytes; an address >= MEM_BYTES is a range error.

Ports:
- CLK  in  1  system clock, rising-edge.
- Reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit idle; a request is accepted when req_valid && req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 01 = half, 10 = word; 11 is treated as word.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; the value is right-aligned (low bits).
- resp_valid  out  1  one-cycle pulse per accepted request.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  2  [0] misaligned, [1] out of range.
- verify_err  out  1  write-verify mismatch; tied 0 when MAU_WRITE_VERIFY_EN is undefined.
- RW  out  1  to DataMemory; 1 = write, 0 = read. DataMemory treats the write as level-sensitive.
- DAddr  out  32  to DataMemory; always word-aligned (bits [1:0] = 0).
- Datain  out  32  to DataMemory; write data.
- DataOut  in  32  from DataMemory; combinational read data.

Behaviour:
- Reset (asynchronous, active-low):
  - State goes to IDLE; all outputs 0 except req_ready = 1.
  - RW drops to 0 immediately, including during STROBE, so no partial write continues.
  - An in-flight request is discarded with no response.
- Request capture: at acceptance the unit registers we, size, unsigned, addr, wdata. req_ready = 1 only in IDLE.
- Little-endian lanes: byte n of a word = bits [8n+7:8n].
- Error check at acceptance:
  - Misaligned: half with addr[0] = 1, or word with addr[1:0] != 0.
  - Out of range: addr >= MEM_BYTES.
  - Either error goes straight to RESP; RW is never asserted.
- FSM states: IDLE, RD, SETUP, STROBE, HOLD, [VERIFY], RESP.
  - IDLE -> error ? RESP : load ? RD : (store word ? SETUP : RD).
  - RD: DAddr = {addr[31:2], 2'b00}, RW = 0; DataOut is registered at the end of the cycle.
  - RD -> RESP for a load; RD -> SETUP for a sub-word store. The merged word is built from the registered read with new lanes inserted.
  - SETUP: DAddr and Datain valid, RW = 0.
  - STROBE: RW = 1 for exactly one cycle.
  - HOLD: RW = 0, DAddr and Datain unchanged.
  - HOLD -> RESP, or HOLD -> VERIFY when the macro is defined.
  - RESP: resp_valid = 1 for one cycle, then IDLE. resp_rdata and resp_err are held until the next RESP.
- Latency, in cycles from the acceptance edge to resp_valid:
  - Error: 1.
  - Load: 2.
  - Store word: 4.
  - Store byte/half: 5.
  - Verify adds +1 to every store.
- DAddr and Datain change only on the IDLE->SETUP, RD->SETUP and IDLE->RD transitions; they are stable through SETUP, STROBE and HOLD.
- Load extension:
  - byte = lane addr[1:0], extended to 32 bits.
  - half = lanes {addr[1],1} : {addr[1],0}, extended to 32 bits.
  - word = unchanged.
- Back-to-back: a new request can be accepted in the cycle after RESP, i.e. the first IDLE cycle.

Optional Feature:
- MAU_WRITE_VERIFY_EN defined:
  - After HOLD, a VERIFY cycle reads back DAddr with RW = 0.
  - verify_err = (DataOut != Datain), registered and presented with resp_valid.
- Undefined: no VERIFY state and verify_err = 0.

Decomposition:
- Package mau_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD;
  - the state enum;
  - error bit indices ERR_MISALIGN/ERR_RANGE.
- One combinational sub-module, mau_lane_merge:
  - insert path: (old word, data, size, addr[1:0]) -> merged word;
  - extract path: (word, size, addr[1:0], unsigned) -> extended data.

Test Plan:
1. SW addr 0x10, data 0xDEADBEEF -> DAddr = 0x10 and Datain = 0xDEADBEEF from cycle 1; RW = 1 only in cycle 2; resp_valid in cycle 4, resp_err = 0. Then LW 0x10 -> resp_rdata = 0xDEADBEEF two cycles after acceptance.
2. SB addr 0x11, data 0x000000A5 over 0xDEADBEEF -> memory word becomes 0xDEADA5EF at cycle 5. LB 0x11 -> 0xFFFFFFA5; LBU 0x11 -> 0x000000A5.
3. SH addr 0x13 -> resp_err = 01 one cycle after acceptance; RW never high; resp_rdata = 0.
4. LW addr 0x400 with MEM_BYTES = 1024 -> resp_err = 10, no memory read.
5. Reset low during STROBE of SW 0x20 -> RW = 0 within the same cycle and no resp_valid. After release, req_ready = 1 and LW 0x20 returns the pre-store value.
6. Macro defined, memory model forcing bit 0 stuck-at-0; SW 0x30, data 0x00000001 -> verify_err = 1 with resp_valid at cycle 5. Without the macro, verify_err stays 0.
